// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the FSM state encoding, port owner encoding, data widths and
// the word-select helper used when a D-side read picks one word out of a line.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  // Address bits that pick a 32-bit word out of a 128-bit line
  localparam int WSEL_LO = 2;
  localparam int WSEL_HI = 3;

  // Lowest address bit that survives line alignment / word alignment
  localparam int LINE_ALIGN_LSB = 4;
  localparam int WORD_ALIGN_LSB = 2;

  // Word k of a line lives in bits [32k+31:32k]
  function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        idx);
    return line[32'(idx) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin picker.
// A lone request always wins; when both sides ask, the side that was not
// served last gets the port. Output is one-hot (or all-zero with no request).
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_served,
  output logic   i_pick,
  output logic   d_pick
);

  // Pick the requester, breaking ties against the side served last
  always_comb begin
    i_pick = 1'b0;
    d_pick = 1'b0;
    if (i_req && d_req) begin
      if (last_served == OWN_D) begin
        i_pick = 1'b1;
      end else begin
        d_pick = 1'b1;
      end
    end else if (i_req) begin
      i_pick = 1'b1;
    end else if (d_req) begin
      d_pick = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache line refill path and the
// D-side word access path. Each granted access holds the memory bus stable
// for MEM_LATENCY cycles, captures the returned line (or one word of it) on
// the last wait edge, then pulses the owner's valid for one cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [LINE_W-1:0] i_line,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [WORD_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [LINE_W-1:0] mem_rline
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  owner_t            last_served;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_we;
  logic              i_pick;
  logic              d_pick;
  logic              busy_done;
  logic              unused_addr_bits;

  // Alignment bits of the request addresses are intentionally dropped
  assign unused_addr_bits = ^{i_addr[LINE_ALIGN_LSB-1:0], d_addr[WORD_ALIGN_LSB-1:0]};

  assign busy_done = (state == BUSY) && (wait_cnt == CNT_LAST);

  mem_arb_rr2 u_rr2 (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_served (last_served),
    .i_pick      (i_pick),
    .d_pick      (d_pick)
  );

  // State register; reset aborts any in-flight access straight to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> BUSY on a grant, BUSY -> RESP on the last wait edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_pick || d_pick) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (busy_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: grants only in IDLE (and never during reset), bus only in BUSY, valid only in RESP
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        i_gnt = i_pick && !rst;
        d_gnt = d_pick && !rst;
      end
      BUSY: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
      end
      RESP: begin
        i_valid = (owner == OWN_I);
        d_valid = (owner == OWN_D);
      end
      default: begin
        i_gnt = 1'b0;
      end
    endcase
  end

  // Latch owner and aligned address/we/wdata at the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_I;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else if (state == IDLE) begin
      if (i_pick) begin
        owner     <= OWN_I;
        lat_addr  <= {i_addr[31:LINE_ALIGN_LSB], {LINE_ALIGN_LSB{1'b0}}};
        lat_we    <= 1'b0;
        lat_wdata <= '0;
      end else if (d_pick) begin
        owner     <= OWN_D;
        lat_addr  <= {d_addr[31:WORD_ALIGN_LSB], {WORD_ALIGN_LSB{1'b0}}};
        lat_we    <= d_we;
        lat_wdata <= d_wdata;
      end
    end
  end

  // Wait counter: cleared while idle, counts each BUSY edge up to the last wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if ((state == BUSY) && !busy_done) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Capture returned data on the last wait edge and remember who was served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_line      <= '0;
      d_rdata     <= '0;
      last_served <= OWN_D;
    end else if (busy_done) begin
      last_served <= owner;
      if (owner == OWN_I) begin
        i_line <= mem_rline;
      end else if (!lat_we) begin
        d_rdata <= select_word(mem_rline, lat_addr[WSEL_HI:WSEL_LO]);
      end
    end
  end

endmodule
